mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read `mem` instance between the CPU's instruction-fetch port and its load/store port. It runs a one-grant-per-cycle arbiter: data has priority and a starvation counter guarantees fetch progress. It drives the memory's `en/we/addr/wdata`, checks alignment and range, and routes the next-cycle `rdata` back to the requester that owns it. It sits between the core pipeline and the unified memory.

---
 rtl/mem_arb_pkg.sv | 5 +
 rtl/mem_arbiter.sv | 73 +++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
    localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-grant-per-cycle arbiter sharing a single-port synchronous-read memory
// between instruction fetch and load/store, with data priority and fetch anti-starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORDS      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    localparam logic [31:0] LIMIT = 32'(WORDS * 4);

    owner_e           own;
    logic             err_q, fav_i, i_bad, d_bad, bad;
    logic [CNT_W-1:0] cnt, cnt_n;

    always_comb begin
        i_gnt   = i_req && (fav_i || !d_req);
        d_gnt   = d_req && !i_gnt;
        i_bad   = (i_addr[1:0] != 2'b00) || (i_addr >= LIMIT);
        d_bad   = (d_addr[1:0] != 2'b00) || (d_addr >= LIMIT);
        bad     = i_gnt ? i_bad : d_bad;
        m_en    = (i_gnt || d_gnt) && !bad;
        m_we    = m_en && d_gnt && d_we;
        m_addr  = m_en ? (i_gnt ? i_addr : d_addr) : '0;
        m_wdata = (m_en && d_gnt) ? d_wdata : '0;
        // only data grants that leave a waiting fetch behind count toward starvation
        cnt_n   = (i_gnt || !i_req) ? '0 : d_gnt ? cnt + 1'b1 : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own   <= OWN_NONE;
            err_q <= 1'b0;
            cnt   <= '0;
            fav_i <= 1'b0;
        end else begin
            own   <= i_gnt ? OWN_I : d_gnt ? OWN_D : OWN_NONE;
            err_q <= (i_gnt || d_gnt) && bad;
            cnt   <= cnt_n;
            fav_i <= i_gnt ? 1'b0 : (cnt_n == CNT_W'(STARVE_MAX)) ? 1'b1 : fav_i;
        end
    end

    always_comb begin
        i_rvalid = own == OWN_I;
        d_rvalid = own == OWN_D;
        i_err    = i_rvalid && err_q;
        d_err    = d_rvalid && err_q;
        i_rdata  = (i_rvalid && !err_q) ? m_rdata : '0;
        d_rdata  = (d_rvalid && !err_q) ? m_rdata : '0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter against a behavioural memory,
// plus hand sequences for starvation and mid-access reset.
module tb_mem_arbiter;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_en, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic        eig, edg, een, ewe;
        logic [31:0] eaddr;
        logic        eirv, eier;
        logic [31:0] eird;
        logic        edrv, eder;
        logic [31:0] edrd;
    } vec_t;

    vec_t vecs [13];

    mem_arbiter #(.WORDS(256), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // synchronous-read memory, read-before-write
    always @(posedge clk) begin
        if (m_en) begin
            m_rdata <= mem[m_addr[9:2]];
            if (m_we) mem[m_addr[9:2]] <= m_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " i_rvalid"}, 32'(i_rvalid), 32'd0);
        chk({nm, " i_rdata"}, i_rdata, 32'd0);
        chk({nm, " i_err"}, 32'(i_err), 32'd0);
        chk({nm, " d_rvalid"}, 32'(d_rvalid), 32'd0);
        chk({nm, " d_rdata"}, d_rdata, 32'd0);
        chk({nm, " d_err"}, 32'(d_err), 32'd0);
    endtask

    // contested fetch 0x10 vs load 0x20; fetch expected on cycles where (k % 5) == 4
    task automatic contest(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(H, 32'h10, H, L, 32'h20, 32'h0);
            #1;
            chk($sformatf("%s c%0d i_gnt", nm, k), 32'(i_gnt), 32'((k % 5) == 4));
            chk($sformatf("%s c%0d d_gnt", nm, k), 32'(d_gnt), 32'((k % 5) != 4));
            chk($sformatf("%s c%0d one_gnt", nm, k), 32'(i_gnt && d_gnt), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("%s c%0d i_rvalid", nm, k), 32'(i_rvalid), 32'((k % 5) == 4));
            chk($sformatf("%s c%0d rdata", nm, k), (k % 5) == 4 ? i_rdata : d_rdata,
                (k % 5) == 4 ? 32'hDEADBEEF : 32'h12345678);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        mem[4]   = 32'hDEADBEEF;
        mem[8]   = 32'hAAAA5555;
        mem[9]   = 32'h11112222;
        mem[255] = 32'h0BADF00D;
        m_rdata  = 32'h0;

        //           ir ia            dr dw da            dwd           ig eg en we addr          irv ier ird           drv der drd
        vecs[0]  = '{H, 32'h10,  L, L, 32'h0,   32'h0,        H, L, H, L, 32'h10,  H, L, 32'hDEADBEEF, L, L, 32'h0};
        vecs[1]  = '{L, 32'h0,   H, H, 32'h20,  32'h12345678, L, H, H, H, 32'h20,  L, L, 32'h0,        H, L, 32'hAAAA5555};
        vecs[2]  = '{L, 32'h0,   H, L, 32'h20,  32'h0,        L, H, H, L, 32'h20,  L, L, 32'h0,        H, L, 32'h12345678};
        vecs[3]  = '{L, 32'h0,   H, L, 32'h22,  32'h0,        L, H, L, L, 32'h0,   L, L, 32'h0,        H, H, 32'h0};
        vecs[4]  = '{L, 32'h0,   H, H, 32'h25,  32'hFFFFFFFF, L, H, L, L, 32'h0,   L, L, 32'h0,        H, H, 32'h0};
        vecs[5]  = '{L, 32'h0,   H, L, 32'h24,  32'h0,        L, H, H, L, 32'h24,  L, L, 32'h0,        H, L, 32'h11112222};
        vecs[6]  = '{L, 32'h0,   H, H, 32'h400, 32'hFFFFFFFF, L, H, L, L, 32'h0,   L, L, 32'h0,        H, H, 32'h0};
        vecs[7]  = '{H, 32'h400, L, L, 32'h0,   32'h0,        H, L, L, L, 32'h0,   H, H, 32'h0,        L, L, 32'h0};
        vecs[8]  = '{H, 32'h3FC, L, L, 32'h0,   32'h0,        H, L, H, L, 32'h3FC, H, L, 32'h0BADF00D, L, L, 32'h0};
        vecs[9]  = '{H, 32'h12,  L, L, 32'h0,   32'h0,        H, L, L, L, 32'h0,   H, H, 32'h0,        L, L, 32'h0};
        vecs[10] = '{L, 32'h0,   L, L, 32'h0,   32'h0,        L, L, L, L, 32'h0,   L, L, 32'h0,        L, L, 32'h0};
        vecs[11] = '{H, 32'h10,  H, L, 32'h20,  32'h0,        L, H, H, L, 32'h20,  L, L, 32'h0,        H, L, 32'h12345678};
        vecs[12] = '{L, 32'h0,   H, L, 32'h0,   32'h0,        L, H, H, L, 32'h0,   L, L, 32'h0,        H, L, 32'h0};

        rst_n = 1'b0;
        drive(L, 32'h0, L, L, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset m_en", 32'(m_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dwd);
            #1;
            chk($sformatf("row%0d i_gnt", i), 32'(i_gnt), 32'(vecs[i].eig));
            chk($sformatf("row%0d d_gnt", i), 32'(d_gnt), 32'(vecs[i].edg));
            chk($sformatf("row%0d m_en", i), 32'(m_en), 32'(vecs[i].een));
            chk($sformatf("row%0d m_we", i), 32'(m_we), 32'(vecs[i].ewe));
            chk($sformatf("row%0d m_addr", i), m_addr, vecs[i].eaddr);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d i_rvalid", i), 32'(i_rvalid), 32'(vecs[i].eirv));
            chk($sformatf("row%0d i_err", i), 32'(i_err), 32'(vecs[i].eier));
            chk($sformatf("row%0d i_rdata", i), i_rdata, vecs[i].eird);
            chk($sformatf("row%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].edrv));
            chk($sformatf("row%0d d_err", i), 32'(d_err), 32'(vecs[i].eder));
            chk($sformatf("row%0d d_rdata", i), d_rdata, vecs[i].edrd);
            @(negedge clk);
        end

        contest("starve", 10);

        // two contested data grants, then reset lands while the second is in flight
        @(negedge clk);
        drive(H, 32'h10, H, L, 32'h20, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre-reset d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk);
        rst_n = 1'b0;
        drive(L, 32'h0, L, L, 32'h0, 32'h0);
        #1;
        chk_quiet("in reset");
        chk("in reset i_gnt", 32'(i_gnt), 32'd0);
        chk("in reset m_en", 32'(m_en), 32'd0);
        @(posedge clk);
        #1;
        chk_quiet("in reset 2");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("released");

        contest("post-reset", 5);

        @(negedge clk);
        drive(L, 32'h0, L, L, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("idle i_rvalid", 32'(i_rvalid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
